// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states and operation encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// Purely combinational CHUNK-bit adder with carry in/out.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] full;

  // Widen by one bit so the carry-out lands in the MSB.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum  = full[CHUNK-1:0];
    cout = full[CHUNK];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH bits processed CHUNK bits per clock,
// carry rippled through a register between chunks, LSB chunk first.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, where sum
// and flags stay frozen until out_ready completes the transfer.
module seq_chunk_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic             chunk_cout;
  logic             chunk_we;
  logic             last_step;
  logic [WIDTH-1:0] sum_next;

  // Select the operand chunk addressed by idx.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_adder_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry_q),
    .sum (chunk_sum),
    .cout(chunk_cout)
  );

  // Merge the fresh chunk into the running sum when a step is taken.
  always_comb begin
    chunk_we  = (state_q == ST_BUSY);
    last_step = chunk_we && (idx_q == IDX_LAST);
    sum_next  = sum_q;
    for (int k = 0; k < N; k++) begin
      if (chunk_we && (idx_q == IDX_W'(k))) begin
        sum_next[k*CHUNK +: CHUNK] = chunk_sum;
      end
    end
  end

  // FSM next-state plus datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + 1, so only b and the initial carry differ.
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          carry_d = (op == OP_SUB) ? 1'b1 : cin;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        sum_d   = sum_next;
        carry_d = chunk_cout;
        if (last_step) begin
          idx_d   = '0;
          cout_d  = chunk_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (sum_next[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (sum_next == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake and result outputs decode directly from registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 32/8 instance (N=4) and an 8/8
// instance (N=1) sharing operand inputs, with separate handshakes.
module tb_seq_chunk_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a, b;
  logic        cin, op;
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] sum32;
  logic        cout32, ovf32, zero32;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  sum8;
  logic        cout8, ovf8, zero8;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .op(op),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Pop the next expected value and compare against an observed one.
  task automatic check_q(input string name, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(name, act, e);
  endtask

  // Route the selected instance's outputs to common names.
  logic        sel8;
  logic        cur_valid, cur_ready_in, cur_cout, cur_ovf, cur_zero;
  logic [31:0] cur_sum;
  always_comb begin
    cur_valid    = sel8 ? out_valid8 : out_valid32;
    cur_ready_in = sel8 ? in_ready8  : in_ready32;
    cur_sum      = sel8 ? {24'h0, sum8} : sum32;
    cur_cout     = sel8 ? cout8 : cout32;
    cur_ovf      = sel8 ? ovf8  : ovf32;
    cur_zero     = sel8 ? zero8 : zero32;
  end

  // ---------------- driver tasks ----------------
  // Present one operation, accept it, and wait (bounded) for out_valid.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic iop, output int lat);
    @(negedge clk);
    a = ia; b = ib; cin = icin; op = iop;
    if (sel8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; in_valid32 = 1'b0;
    lat = 0;
    while (!cur_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic complete();
    @(negedge clk);
    out_ready32 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready32 = 1'b0; out_ready8 = 1'b0;
    check("out_valid_drop", {31'h0, cur_valid}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        use8;
    logic [31:0] va, vb;
    logic        vcin, vop;
    int          exp_lat;
    logic [31:0] exp_sum;
    logic        exp_cout, exp_ovf, exp_zero;
  } vec_t;

  vec_t vecs[8];
  int   lat;
  logic [31:0] held_sum;

  initial begin
    vecs[0] = '{"add_ff_1",     1'b0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 4, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple",   1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"add_ovf",      1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"sub_borrow",   1'b0, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"sub_ovf",      1'b0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 4, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    // cin must be ignored for subtract
    vecs[5] = '{"sub_equal",    1'b0, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 4, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"n1_add_ff_1",  1'b1, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"n1_add_ripple",1'b1, 32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1, 32'h00000000, 1'b1, 1'b0, 1'b1};

    a = '0; b = '0; cin = 1'b0; op = 1'b0; sel8 = 1'b0;
    in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready32 = 1'b0; out_ready8 = 1'b0;

    // Reset state, sampled while rst is still asserted.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid32}, 32'h0);
    check("rst_sum", sum32, 32'h0);
    check("rst_flags", {29'h0, cout32, ovf32, zero32}, 32'h0);
    check("rst_out_valid8", {31'h0, out_valid8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {30'h0, in_ready32, in_ready8}, 32'h3);

    // Table-driven operations.
    for (int i = 0; i < 8; i++) begin
      sel8 = vecs[i].use8;
      issue(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vop, lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_sum"}, cur_sum, vecs[i].exp_sum);
      check({vecs[i].name, "_cout"}, {31'h0, cur_cout}, {31'h0, vecs[i].exp_cout});
      check({vecs[i].name, "_ovf"}, {31'h0, cur_ovf}, {31'h0, vecs[i].exp_ovf});
      check({vecs[i].name, "_zero"}, {31'h0, cur_zero}, {31'h0, vecs[i].exp_zero});
      complete();
    end
    sel8 = 1'b0;

    // Backpressure: result held for 3 DONE cycles, stray in_valid ignored.
    issue(32'h11111111, 32'h22222222, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 4);
    held_sum = 32'h33333333;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(held_sum);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h0);
      if (c == 1) begin
        @(negedge clk);
        a = 32'hAAAAAAAA; b = 32'h55555555; in_valid32 = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      check_q("bp_sum_hold", sum32);
      check_q("bp_out_valid", {31'h0, out_valid32});
      check_q("bp_in_ready", {31'h0, in_ready32});
    end
    check("bp_flags", {29'h0, cout32, ovf32, zero32}, 32'h0);
    complete();
    check("bp_idle_ready", {31'h0, in_ready32}, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("bp_no_queue", {31'h0, out_valid32}, 32'h0);

    // Reset during BUSY at idx=2: nothing presented, outputs cleared.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; op = 1'b0; in_valid32 = 1'b1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, out_valid32}, 32'h0);
    check("midrst_sum", sum32, 32'h0);
    check("midrst_flags", {29'h0, cout32, ovf32, zero32}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'h0, in_ready32}, 32'h1);
    issue(32'h00000010, 32'h00000020, 1'b0, 1'b0, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_sum", sum32, 32'h00000030);
    check("post_rst_flags", {29'h0, cout32, ovf32, zero32}, 32'h0);
    complete();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
